// File: rtl/io_bus_unit.sv
// Memory-mapped IO peripheral: LED register, debounced button with switch-capture handshake,
// 8-digit hex display scanner and a free-running cycle counter.
module io_bus_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SCAN_DIV        = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [3:0]  seg_hex
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [7:0] ADDR_LED    = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_SWDATA = 8'h08;
  localparam logic [7:0] ADDR_SEG    = 8'h10;
  localparam logic [7:0] ADDR_CYCLES = 8'h18;

  logic             btn_s1, btn_s2;
  logic [15:0]      sw_s1, sw_s2;
  logic [1:0]       sync_fill;
  logic             press_block;
  logic             deb_level;
  logic [DB_W-1:0]  deb_cnt;
  logic             press;
  logic [15:0]      sw_latch;
  logic             in_valid, overrun;
  logic [31:0]      seg_data, cycles;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       digit_idx;

  logic             wr_led, wr_status, wr_seg, wr_cycles;
  logic             deb_flip, div_wrap;
  logic [2:0]       idx_nx;
  logic [31:0]      seg_nx;

  // Write decode and next-state terms shared by several registers
  always_comb begin
    wr_led    = io_we && (io_addr == ADDR_LED);
    wr_status = io_we && (io_addr == ADDR_STATUS);
    wr_seg    = io_we && (io_addr == ADDR_SEG);
    wr_cycles = io_we && (io_addr == ADDR_CYCLES);
    deb_flip  = (btn_s2 != deb_level) && (deb_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    div_wrap  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    idx_nx    = div_wrap ? digit_idx + 3'd1 : digit_idx;
    seg_nx    = wr_seg ? io_dout : seg_data;
  end

  // Read mux; reads have no side effects
  always_comb begin
    io_din = 32'h0;
    case (io_addr)
      ADDR_LED:    io_din = {16'h0, led};
      ADDR_STATUS: io_din = {30'h0, overrun, in_valid};
      ADDR_SWDATA: io_din = {16'h0, sw_latch};
      ADDR_SEG:    io_din = seg_data;
      ADDR_CYCLES: io_din = cycles;
      default:     io_din = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1      <= 1'b0;
      btn_s2      <= 1'b0;
      sw_s1       <= 16'h0;
      sw_s2       <= 16'h0;
      sync_fill   <= 2'b00;
      press_block <= 1'b1;
      deb_level   <= 1'b0;
      deb_cnt     <= '0;
      press       <= 1'b0;
      sw_latch    <= 16'h0;
      in_valid    <= 1'b0;
      overrun     <= 1'b0;
      led         <= 16'h0;
      seg_data    <= 32'h0;
      cycles      <= 32'h0;
      div_cnt     <= '0;
      digit_idx   <= 3'd0;
      an          <= 8'hFE;
      seg_hex     <= 4'h0;
    end else begin
      btn_s1    <= btn;
      btn_s2    <= btn_s1;
      sw_s1     <= sw;
      sw_s2     <= sw_s1;
      sync_fill <= {sync_fill[0], 1'b1};

      // A button held through reset stays blocked until it is seen released
      if (sync_fill[1] && !btn_s2) begin
        press_block <= 1'b0;
      end

      if (btn_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_flip) begin
        deb_level <= ~deb_level;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DB_W'(1);
      end
      press <= deb_flip && !deb_level && !press_block;

      // A press coinciding with an ack is accepted as a fresh capture
      if (press) begin
        if (wr_status || !in_valid) begin
          sw_latch <= sw_s2;
          in_valid <= 1'b1;
          overrun  <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (wr_status) begin
        in_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      if (wr_led) begin
        led <= io_dout[15:0];
      end
      seg_data <= seg_nx;
      cycles   <= wr_cycles ? io_dout : cycles + 32'd1;

      // Display outputs follow the next index and data so a SEG write shows immediately
      div_cnt   <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      digit_idx <= idx_nx;
      an        <= ~(8'd1 << idx_nx);
      seg_hex   <= seg_nx[{idx_nx, 2'b00} +: 4];
    end
  end

endmodule
